clock_step_ctrl: RTL
====================

Name: clock_step_ctrl

Overview:
- Front-panel run/step/halt controller for the processor clock; sits directly upstream of the positive-edge clock gate and drives its enable input.
- Synchronises and debounces three push-buttons and accepts a halt request from the CPU.
- Produces a registered enable that lets exactly the intended number of rising clock edges through: free-run, N-edge burst, or none.
- Counts gated edges for the debug display.

Parameters:
SYNC_STAGES, 2, flip-flop synchroniser depth per button input (min 2)
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to change a debounced level (min 1)
CNT_W, 8, width of burst length and remaining-edge counter

Ports:
clk  in  1  free-running system clock, the same clock that feeds the edge gate
rst_n  in  1  asynchronous active-low reset
run_btn  in  1  raw asynchronous run button, active high
step_btn  in  1  raw asynchronous step button, active high
halt_btn  in  1  raw asynchronous halt button, active high
cpu_halt  in  1  synchronous halt request from the CPU, level, active high
burst_len  in  CNT_W  edges per step press; 0 is treated as 1
en  out  1  registered enable to the edge gate
running  out  1  high in RUN state
stepping  out  1  high in BURST state
edges_left  out  CNT_W  remaining edges of the current burst, 0 outside BURST
edge_count  out  32  total gated edges since reset, wraps at 2^32

Behaviour:
- One clock: clk. Reset is asynchronous and active-low (rst_n). All state updates on rising clk edge.
- Reset: state HALT; en=0, running=0, stepping=0, edges_left=0, edge_count=0; synchronisers, debounced levels and debounce counters all 0.
- Button path: each button passes through SYNC_STAGES FFs. A per-button counter increments while the synchronised sample differs from the debounced level and clears when they match. Reaching DEBOUNCE_CYCLES flips the debounced level and clears the counter.
- A 0->1 debounced transition gives a one-cycle press pulse. A 1->0 transition gives nothing.
- A button held through reset yields one press after the debounce time.
- Event latency: with a clean input high before edge 1, the press pulse is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES. en and state change at the next edge.
- Gated-edge rule: edge k passes the downstream gate iff en==1 in the cycle before edge k. edge_count increments at every edge where en was 1.
- States:
  - HALT: en=0. A run press goes to RUN. A step press loads edges_left = max(burst_len,1) and goes to BURST. burst_len is sampled only on the press cycle.
  - RUN: en=1. A halt press or cpu_halt goes to HALT. Step and run presses are ignored.
  - BURST: en=1. edges_left decrements by 1 each cycle. The cycle holding edges_left==1 transitions to HALT. Result: exactly max(burst_len,1) cycles with en=1. Run and step presses are ignored. A halt press or cpu_halt aborts to HALT, and edges_left clears to 0.
- Priority, same cycle: halt press or cpu_halt > step press > run press.
- cpu_halt asserted in HALT keeps the controller in HALT and blocks run and step presses while high.
- cpu_halt high before edge k with en=1: edge k still passes, en=0 after edge k, edge k+1 is blocked.
- running, stepping and en are registered together; no combinational paths from inputs to outputs.
- rst_n asserted mid-burst or mid-run: all outputs go to reset values immediately, with no further gated edges.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Reset, then hold run_btn high from edge 1 -> press pulse after edge 6; en and running go high after edge 7; edge_count=10 after 10 further edges.
- Glitchy step_btn: high for 3 cycles, low 1, high 3, then low -> no press; state stays HALT; en=0 throughout.
- HALT, burst_len=5, step press -> en high for exactly 5 cycles; edges_left 5,4,3,2,1 then 0; edge_count +5; returns to HALT.
- burst_len=0, step press -> exactly 1 enabled cycle; edge_count +1.
- RUN, cpu_halt pulsed high 1 cycle -> en low after that edge; later run press resumes RUN. Same cycle as a step press: result is HALT.
- BURST of 200 with rst_n dropped after 50 cycles -> en=0 immediately; edge_count=0; state HALT after release.

Source files
------------

// File: rtl/clock_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_step_ctrl
//  Description : Front-panel run / step / halt controller for the processor
//                clock. Synchronises and debounces three push-buttons, accepts
//                a CPU halt request and drives the registered enable of the
//                downstream positive-edge clock gate. Counts gated edges.
//  Ports       : clk            free-running clock (same as the edge gate)
//                rst_n          asynchronous active-low reset
//                run_btn_i      raw run button, active high
//                step_btn_i     raw step button, active high
//                halt_btn_i     raw halt button, active high
//                cpu_halt_i     synchronous CPU halt request, level
//                burst_len_i    edges per step press (0 behaves as 1)
//                en_o           registered enable to the edge gate
//                running_o      high in RUN
//                stepping_o     high in BURST
//                edges_left_o   remaining edges of the current burst
//                edge_count_o   gated edges since reset, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_step_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_btn_i,
    input  logic             step_btn_i,
    input  logic             halt_btn_i,
    input  logic             cpu_halt_i,
    input  logic [CNT_W-1:0] burst_len_i,
    output logic             en_o,
    output logic             running_o,
    output logic             stepping_o,
    output logic [CNT_W-1:0] edges_left_o,
    output logic [31:0]      edge_count_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // Button order in the vectors: 0 = run, 1 = step, 2 = halt
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {halt_btn_i, step_btn_i, run_btn_i};

    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DBW-1:0]         db_cnt_q;
        logic                   level_q;
        logic                   press_q;
        logic                   sample;

        assign sample = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q   <= '0;
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                press_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw[b]};
                press_q <= 1'b0;
                if (sample == level_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    // This edge is the DEBOUNCE_CYCLES-th differing sample
                    level_q  <= sample;
                    db_cnt_q <= '0;
                    press_q  <= sample;    // rising level only
                end else begin
                    db_cnt_q <= db_cnt_q + DBW'(1);
                end
            end
        end

        assign press[b] = press_q;
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   edges_left_q, edges_left_d;
    logic               en_q, en_d;
    logic               running_q, running_d;
    logic               stepping_q, stepping_d;
    logic [31:0]        edge_count_q;
    logic               halt_req;

    assign halt_req = press[2] | cpu_halt_i;

    always_comb begin
        state_d      = state_q;
        edges_left_d = edges_left_q;
        case (state_q)
            ST_HALT: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (press[1]) begin
                    state_d      = ST_BURST;
                    edges_left_d = (burst_len_i == '0) ? CNT_W'(1) : burst_len_i;
                end else if (press[0]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_BURST: begin
                if (halt_req || edges_left_q == CNT_W'(1)) begin
                    state_d      = ST_HALT;
                    edges_left_d = '0;
                end else begin
                    edges_left_d = edges_left_q - CNT_W'(1);
                end
            end
            default: begin
                state_d      = ST_HALT;
                edges_left_d = '0;
            end
        endcase
        // Outputs are decoded from the next state so they register with it
        en_d       = (state_d != ST_HALT);
        running_d  = (state_d == ST_RUN);
        stepping_d = (state_d == ST_BURST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HALT;
            edges_left_q <= '0;
            en_q         <= 1'b0;
            running_q    <= 1'b0;
            stepping_q   <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            edges_left_q <= edges_left_d;
            en_q         <= en_d;
            running_q    <= running_d;
            stepping_q   <= stepping_d;
            // An edge passes the gate when en was high before it
            edge_count_q <= edge_count_q + 32'(en_q);
        end
    end

    assign en_o         = en_q;
    assign running_o    = running_q;
    assign stepping_o   = stepping_q;
    assign edges_left_o = edges_left_q;
    assign edge_count_o = edge_count_q;

endmodule
`default_nettype wire
